auth_credential_entry: RTL and testbench

Credential-entry controller that drives the authentication comparator. It collects a 3-bit user code and a 3-bit password from switches, one enter-button press for each. It presents the 6-bit credential on the comparator's A..F inputs and samples the 3-bit AUT result. It then holds an access session, applying failed-attempt lockout and an inactivity timeout.

---
 rtl/auth_pkg.sv | 29 ++
 rtl/rise_edge_detect.sv | 19 +
 rtl/auth_credential_entry.sv | 157 +++++++++++++++
 tb/tb_auth_credential_entry.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared types and constants for the credential-entry controller.
// Holds the FSM encoding, access-level codes and credential field positions.
package auth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PASS = 3'd1,
    ST_CHECK     = 3'd2,
    ST_GRANTED   = 3'd3,
    ST_LOCKED    = 3'd4
  } state_e;

  localparam logic [1:0] LVL_NONE = 2'd0;
  localparam logic [1:0] LVL_3    = 2'd1;
  localparam logic [1:0] LVL_2    = 2'd2;
  localparam logic [1:0] LVL_1    = 2'd3;

  localparam int USER_MSB = 5;
  localparam int PASS_MSB = 2;

  // Highest asserted comparator bit wins; AUT1 is the strongest grant.
  function automatic logic [1:0] aut_to_level(input logic [2:0] aut);
    if (aut[2])      return LVL_1;
    else if (aut[1]) return LVL_2;
    else if (aut[0]) return LVL_3;
    else             return LVL_NONE;
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge pulse from a synchronous level; prev flop resets high so a
// level held through reset release never produces a pulse.
module rise_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic pulse_o
);

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_q <= 1'b1;
    else     prev_q <= level_i;
  end

  assign pulse_o = level_i & ~prev_q;

endmodule

// File: rtl/auth_credential_entry.sv
// Collects user code and password, checks them against the comparator result,
// then runs the granted session with inactivity timeout and failed-attempt lockout.
module auth_credential_entry
  import auth_pkg::*;
#(
  parameter int LOCK_CYCLES    = 1000,
  parameter int SESSION_CYCLES = 5000,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw_code,
  input  logic       btn_enter,
  input  logic       btn_logout,
  output logic [5:0] cred,
  input  logic [2:0] aut,
  output logic [1:0] access_level,
  output logic       session_active,
  output logic       locked,
  output logic [1:0] fail_count,
  output logic       auth_ok,
  output logic       auth_fail
);

  localparam int TMAX = (LOCK_CYCLES > SESSION_CYCLES) ? LOCK_CYCLES : SESSION_CYCLES;
  localparam int TW   = $clog2(TMAX);

  state_e          state_q, state_d;
  logic [2:0]      user_q, user_d;
  logic [2:0]      pass_q, pass_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [1:0]      level_q, level_d;
  logic [1:0]      fails_q, fails_d;
  logic            ok_q, ok_d;
  logic            fail_q, fail_d;
  logic            enter_evt, logout_evt;
  logic [1:0]      fail_inc;
  logic [TW-1:0]   timer_inc;
  logic            lock_done, session_done;

  rise_edge_detect u_enter_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_enter),
    .pulse_o (enter_evt)
  );

  rise_edge_detect u_logout_edge (
    .clk     (clk),
    .rst     (rst),
    .level_i (btn_logout),
    .pulse_o (logout_evt)
  );

  assign fail_inc     = fails_q + 2'd1;
  assign timer_inc    = (timer_q == {TW{1'b1}}) ? timer_q : timer_q + 1'b1;
  assign lock_done    = (timer_q == TW'(LOCK_CYCLES - 1));
  assign session_done = (timer_q == TW'(SESSION_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (enter_evt) state_d = ST_WAIT_PASS;
      ST_WAIT_PASS: begin
        if (logout_evt)     state_d = ST_IDLE;
        else if (enter_evt) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (aut != 3'd0)                    state_d = ST_GRANTED;
        else if (int'(fail_inc) == MAX_FAILS) state_d = ST_LOCKED;
        else                                state_d = ST_IDLE;
      end
      ST_GRANTED: begin
        if (logout_evt)                       state_d = ST_IDLE;
        else if (!enter_evt && session_done)  state_d = ST_IDLE;
      end
      ST_LOCKED:    if (lock_done) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Timer is zero outside GRANTED/LOCKED, so entry to either starts it at 0.
  always_comb begin
    user_d  = user_q;
    pass_d  = pass_q;
    timer_d = '0;
    level_d = level_q;
    fails_d = fails_q;
    ok_d    = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      ST_IDLE:      if (enter_evt) user_d = sw_code;
      ST_WAIT_PASS: if (!logout_evt && enter_evt) pass_d = sw_code;
      ST_CHECK: begin
        if (aut != 3'd0) begin
          level_d = aut_to_level(aut);
          fails_d = 2'd0;
          ok_d    = 1'b1;
        end else begin
          fails_d = fail_inc;
          fail_d  = 1'b1;
        end
      end
      ST_GRANTED: begin
        timer_d = enter_evt ? '0 : timer_inc;
        if (state_d == ST_IDLE) level_d = LVL_NONE;
      end
      ST_LOCKED: begin
        timer_d = timer_inc;
        if (state_d == ST_IDLE) fails_d = 2'd0;
      end
      default: ;
    endcase
    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      user_d = 3'd0;
      pass_d = 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_q  <= 3'd0;
      pass_q  <= 3'd0;
      timer_q <= '0;
      level_q <= LVL_NONE;
      fails_q <= 2'd0;
      ok_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      user_q  <= user_d;
      pass_q  <= pass_d;
      timer_q <= timer_d;
      level_q <= level_d;
      fails_q <= fails_d;
      ok_q    <= ok_d;
      fail_q  <= fail_d;
    end
  end

  always_comb begin
    session_active = (state_q == ST_GRANTED);
    locked         = (state_q == ST_LOCKED);
  end

  assign cred[USER_MSB -: 3] = user_q;
  assign cred[PASS_MSB -: 3] = pass_q;
  assign access_level        = level_q;
  assign fail_count          = fails_q;
  assign auth_ok             = ok_q;
  assign auth_fail           = fail_q;

endmodule

// File: tb/tb_auth_credential_entry.sv
// Bench for auth_credential_entry: directed scenarios plus random button traffic,
// every cycle compared against a countdown-based behavioural model.
module tb_auth_credential_entry;

  localparam int LOCK    = 8;
  localparam int SESSION = 16;
  localparam int MAXF    = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] sw_code = 3'd0;
  logic       btn_enter = 1'b1;
  logic       btn_logout = 1'b0;
  logic [5:0] cred;
  logic [2:0] aut = 3'd0;
  logic [1:0] access_level;
  logic       session_active;
  logic       locked;
  logic [1:0] fail_count;
  logic       auth_ok;
  logic       auth_fail;

  int checks = 0;
  int errors = 0;

  auth_credential_entry #(
    .LOCK_CYCLES    (LOCK),
    .SESSION_CYCLES (SESSION),
    .MAX_FAILS      (MAXF)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sw_code        (sw_code),
    .btn_enter      (btn_enter),
    .btn_logout     (btn_logout),
    .cred           (cred),
    .aut            (aut),
    .access_level   (access_level),
    .session_active (session_active),
    .locked         (locked),
    .fail_count     (fail_count),
    .auth_ok        (auth_ok),
    .auth_fail      (auth_fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: phase name plus remaining-cycle countdowns.
  string m_phase;
  bit    m_prev_e, m_prev_l;
  int    m_user, m_pass, m_level, m_fails, m_left;
  bit    m_ok, m_bad;

  task automatic model_reset();
    m_phase = "idle";
    m_prev_e = 1; m_prev_l = 1;
    m_user = 0; m_pass = 0; m_level = 0; m_fails = 0; m_left = 0;
    m_ok = 0; m_bad = 0;
  endtask

  task automatic to_idle();
    m_phase = "idle";
    m_user = 0;
    m_pass = 0;
  endtask

  task automatic model_step();
    bit ev_e, ev_l;
    ev_e = btn_enter && !m_prev_e;
    ev_l = btn_logout && !m_prev_l;
    m_prev_e = btn_enter;
    m_prev_l = btn_logout;
    m_ok = 0;
    m_bad = 0;
    if (m_phase == "idle") begin
      if (ev_e) begin m_user = sw_code; m_phase = "wait"; end
    end else if (m_phase == "wait") begin
      if (ev_l) to_idle();
      else if (ev_e) begin m_pass = sw_code; m_phase = "check"; end
    end else if (m_phase == "check") begin
      if (aut != 0) begin
        m_level = aut[2] ? 3 : (aut[1] ? 2 : 1);
        m_fails = 0;
        m_ok = 1;
        m_phase = "granted";
        m_left = SESSION;
      end else begin
        m_bad = 1;
        m_fails++;
        if (m_fails == MAXF) begin m_phase = "locked"; m_left = LOCK; end
        else to_idle();
      end
    end else if (m_phase == "granted") begin
      if (ev_l) begin to_idle(); m_level = 0; end
      else if (ev_e) m_left = SESSION;
      else begin
        m_left--;
        if (m_left == 0) begin to_idle(); m_level = 0; end
      end
    end else if (m_phase == "locked") begin
      m_left--;
      if (m_left == 0) begin to_idle(); m_fails = 0; end
    end
  endtask

  task automatic compare_all();
    check("cred",    8'(cred),           8'(m_user * 8 + m_pass));
    check("level",   8'(access_level),   8'(m_level));
    check("session", 8'(session_active), 8'(m_phase == "granted"));
    check("locked",  8'(locked),         8'(m_phase == "locked"));
    check("fails",   8'(fail_count),     8'(m_fails));
    check("ok",      8'(auth_ok),        8'(m_ok));
    check("bad",     8'(auth_fail),      8'(m_bad));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    #1;
    compare_all();
  endtask

  task automatic press(input logic [2:0] v);
    sw_code = v;
    btn_enter = 1'b1;
    tick();
    btn_enter = 1'b0;
    tick();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cred"},  8'(cred), 8'd0);
    check({tag, "_level"}, 8'(access_level), 8'd0);
    check({tag, "_outs"},  8'({session_active, locked, auth_ok, auth_fail, fail_count}), 8'd0);
  endtask

  initial begin
    model_reset();
    #2;
    check_all_zero("reset");
    // Enter held high through reset release must not capture.
    sw_code = 3'b111;
    #20 rst = 1'b0;
    idle_ticks(3);
    check("held_enter_cred", 8'(cred), 8'd0);
    btn_enter = 1'b0;
    tick();

    // Grant path with AUT1.
    aut = 3'b100;
    press(3'b011);
    sw_code = 3'b100;
    btn_enter = 1'b1;
    tick();
    check("grant_cred", 8'(cred), 8'b011100);
    btn_enter = 1'b0;
    tick();
    check("grant_level", 8'(access_level), 8'd3);
    check("grant_session", 8'(session_active), 8'd1);
    idle_ticks(SESSION + 2);
    check("timeout_session", 8'(session_active), 8'd0);

    // Priority grants, then logout / extended session.
    aut = 3'b011;
    press(3'b001); press(3'b010);
    check("prio_lvl2", 8'(access_level), 8'd2);
    btn_logout = 1'b1; tick(); btn_logout = 1'b0; tick();
    aut = 3'b001;
    press(3'b101); press(3'b110);
    check("prio_lvl3", 8'(access_level), 8'd1);
    idle_ticks(8);
    press(3'b000);
    idle_ticks(SESSION + 4);

    // Lockout after three failures, enter ignored while locked.
    aut = 3'b000;
    for (int k = 0; k < 3; k++) begin
      press(3'(k)); press(3'(k + 1));
    end
    check("lock_state", 8'(locked), 8'd1);
    press(3'b010);
    idle_ticks(LOCK);
    check("lock_released", 8'(locked), 8'd0);

    // Abort: enter and logout together in WAIT_PASS.
    press(3'b110);
    btn_enter = 1'b1; btn_logout = 1'b1; tick();
    btn_enter = 1'b0; btn_logout = 1'b0; tick();
    check("abort_cred", 8'(cred), 8'd0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      btn_enter  = ($urandom_range(0, 2) == 0);
      btn_logout = ($urandom_range(0, 19) == 0);
      sw_code    = 3'($urandom_range(0, 7));
      aut        = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      tick();
    end
    btn_enter = 1'b0; btn_logout = 1'b0;
    idle_ticks(2 * SESSION);
    btn_logout = 1'b1; tick(); btn_logout = 1'b0; tick();

    // Reset asserted during CHECK clears outputs without a clock edge.
    aut = 3'b111;
    press(3'b101);
    sw_code = 3'b011;
    btn_enter = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    check_all_zero("rst_in_check");
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    idle_ticks(2);
    btn_enter = 1'b0;
    idle_ticks(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
